// File: rtl/clct_key_deadtime_ctrl_pkg.sv
// rtl/clct_key_deadtime_ctrl_pkg.sv - shared widths and pattern field helpers for the key dead-time controller
package clct_key_deadtime_ctrl_pkg;
  localparam int MXPATB = 7;
  localparam int MXKEYB = 5;
  localparam int MXKEY  = 32;
  localparam int MXHITB = 3;
  localparam int MXDTB  = 4;
  localparam int SPAN   = 2;
  localparam int MXPIDB = MXPATB - MXHITB;

  function automatic logic [MXHITB-1:0] pat_hits(input logic [MXPATB-1:0] pat);
    return pat[MXPATB-1 -: MXHITB];
  endfunction

  function automatic logic [MXPIDB-1:0] pat_id(input logic [MXPATB-1:0] pat);
    return pat[MXPIDB-1:0];
  endfunction
endpackage

// File: rtl/clct_key_deadtime_ctrl_deadtimer.sv
// rtl/clct_key_deadtime_ctrl_deadtimer.sv - per-key dead-time down-counter driving one busy bit
module clct_key_deadtimer
  import clct_key_deadtime_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [MXDTB-1:0] dead_bx,
  output logic             busy
);
  logic [MXDTB-1:0] cnt;

  // A zero dead time never loads, so such keys stay free every clock.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      cnt <= '0;
    end else if (load && (dead_bx != '0)) begin
      cnt <= dead_bx;
    end else if (cnt != '0) begin
      cnt <= cnt - MXDTB'(1);
    end
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/clct_key_deadtime_ctrl.sv
// rtl/clct_key_deadtime_ctrl.sv - accepts the sorter best pattern and blanks neighbouring keys for a dead time
module clct_key_deadtime_ctrl
  import clct_key_deadtime_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [MXDTB-1:0]  dead_bx,
  input  logic [MXHITB-1:0] hit_thr,
  input  logic [MXPATB-1:0] best_pat,
  input  logic [MXKEYB-1:0] best_key,
  input  logic              best_bsy,
  output logic [MXKEY-1:0]  bsy,
  output logic              clct_vld,
  output logic [MXPATB-1:0] clct_pat,
  output logic [MXKEYB-1:0] clct_key
);
  logic [MXHITB-1:0] hits;
  logic [MXKEYB:0]   key_ext;
  logic              accept;
  logic [MXKEY-1:0]  load;

  assign hits    = pat_hits(best_pat);
  assign key_ext = {1'b0, best_key};

  // The sorter output lags the mask by one clock, so our own mask must veto it.
  assign accept = enable & ~best_bsy & ~bsy[best_key] &
                  (hits >= hit_thr) & (hits != '0);

  for (genvar k = 0; k < MXKEY; k++) begin : g_key
    localparam logic [MXKEYB:0] KPOS = (MXKEYB+1)'(k);
    localparam logic [MXKEYB:0] KHI  = (MXKEYB+1)'(k + SPAN);

    // |k - K| <= SPAN, evaluated one bit wider so the window clips at 0 and MXKEY-1.
    assign load[k] = accept && (key_ext <= KHI) &&
                     (KPOS <= key_ext + (MXKEYB+1)'(SPAN));

    clct_key_deadtimer u_deadtimer (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush),
      .load    (load[k]),
      .dead_bx (dead_bx),
      .busy    (bsy[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clct_vld <= 1'b0;
      clct_pat <= '0;
      clct_key <= '0;
    end else begin
      clct_vld <= accept;
      if (accept) begin
        clct_pat <= best_pat;
        clct_key <= best_key;
      end
    end
  end
endmodule

// File: tb/tb_clct_key_deadtime_ctrl.sv
// tb/tb_clct_key_deadtime_ctrl.sv - self-checking bench: vector table, scoreboard model and corner sequences
module tb_clct_key_deadtime_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        best_bsy = 1'b0;
  logic [3:0]  dead_bx = '0;
  logic [2:0]  hit_thr = '0;
  logic [6:0]  best_pat = '0;
  logic [4:0]  best_key = '0;
  logic [31:0] bsy;
  logic        clct_vld;
  logic [6:0]  clct_pat;
  logic [4:0]  clct_key;

  always #5 clock = ~clock;

  clct_key_deadtime_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .flush    (flush),
    .dead_bx  (dead_bx),
    .hit_thr  (hit_thr),
    .best_pat (best_pat),
    .best_key (best_key),
    .best_bsy (best_bsy),
    .bsy      (bsy),
    .clct_vld (clct_vld),
    .clct_pat (clct_pat),
    .clct_key (clct_key)
  );

  typedef struct {
    logic        vld;
    logic [6:0]  pat;
    logic [4:0]  key;
    logic [31:0] bsy;
  } sb_t;

  typedef struct {
    logic        en;
    logic [6:0]  pat;
    logic [4:0]  key;
    logic        bb;
    logic [2:0]  thr;
    logic [3:0]  dead;
    logic        vld;
    logic [31:0] bsy;
  } vec_t;

  sb_t  sbq[$];
  sb_t  mst;
  int   mcnt[32];
  vec_t vt[12];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic [6:0] pat, input logic [4:0] key,
                        input logic bb, input logic [2:0] thr, input logic [3:0] dead);
    enable = en; best_pat = pat; best_key = key; best_bsy = bb; hit_thr = thr; dead_bx = dead;
  endtask

  task automatic idle();
    best_pat = '0;
    best_bsy = 1'b0;
  endtask

  task automatic model_push();
    logic acc;
    int   hits;
    sb_t  e;
    hits = int'(best_pat[6:4]);
    if (reset) begin
      foreach (mcnt[k]) mcnt[k] = 0;
      mst = '{1'b0, 7'h0, 5'h0, 32'h0};
    end else begin
      acc = enable && !best_bsy && (mcnt[best_key] == 0) && (hits >= int'(hit_thr)) && (hits != 0);
      mst.vld = acc;
      if (acc) begin
        mst.pat = best_pat;
        mst.key = best_key;
      end
      for (int k = 0; k < 32; k++) begin
        if (flush) mcnt[k] = 0;
        else if (acc && (k >= int'(best_key) - 2) && (k <= int'(best_key) + 2) && (dead_bx != 0))
          mcnt[k] = int'(dead_bx);
        else if (mcnt[k] > 0) mcnt[k] = mcnt[k] - 1;
      end
    end
    e = mst;
    e.bsy = '0;
    for (int k = 0; k < 32; k++) e.bsy[k] = (mcnt[k] != 0);
    sbq.push_back(e);
  endtask

  task automatic cycle();
    sb_t e;
    model_push();
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    chk("sb_vld", 32'(clct_vld), 32'(e.vld));
    chk("sb_pat", 32'(clct_pat), 32'(e.pat));
    chk("sb_key", 32'(clct_key), 32'(e.key));
    chk("sb_bsy", bsy, e.bsy);
  endtask

  task automatic clean();
    idle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    int n;
    mst = '{1'b0, 7'h0, 5'h0, 32'h0};
    foreach (mcnt[k]) mcnt[k] = 0;

    vt[0]  = '{1'b1, 7'h62, 5'd10, 1'b0, 3'd3, 4'd4, 1'b1, 32'h0000_1F00};
    vt[1]  = '{1'b1, 7'h62, 5'd0,  1'b0, 3'd3, 4'd4, 1'b1, 32'h0000_0007};
    vt[2]  = '{1'b1, 7'h62, 5'd31, 1'b0, 3'd3, 4'd4, 1'b1, 32'hE000_0000};
    vt[3]  = '{1'b1, 7'h62, 5'd1,  1'b0, 3'd3, 4'd4, 1'b1, 32'h0000_000F};
    vt[4]  = '{1'b1, 7'h62, 5'd30, 1'b0, 3'd3, 4'd4, 1'b1, 32'hF000_0000};
    vt[5]  = '{1'b1, 7'h25, 5'd10, 1'b0, 3'd3, 4'd4, 1'b0, 32'h0000_0000};
    vt[6]  = '{1'b1, 7'h5A, 5'd10, 1'b1, 3'd3, 4'd4, 1'b0, 32'h0000_0000};
    vt[7]  = '{1'b0, 7'h62, 5'd10, 1'b0, 3'd3, 4'd4, 1'b0, 32'h0000_0000};
    vt[8]  = '{1'b1, 7'h0F, 5'd4,  1'b0, 3'd0, 4'd4, 1'b0, 32'h0000_0000};
    vt[9]  = '{1'b1, 7'h62, 5'd3,  1'b0, 3'd3, 4'd0, 1'b1, 32'h0000_0000};
    vt[10] = '{1'b1, 7'h7F, 5'd16, 1'b0, 3'd7, 4'd2, 1'b1, 32'h0007_C000};
    vt[11] = '{1'b1, 7'h43, 5'd20, 1'b0, 3'd4, 4'd1, 1'b1, 32'h007C_0000};

    repeat (2) cycle();
    reset = 1'b0;
    cycle();

    // reset with counters loaded and outputs holding non-zero values
    set_in(1'b1, 7'h62, 5'd10, 1'b0, 3'd3, 4'd4);
    cycle();
    idle();
    cycle();
    reset = 1'b1;
    repeat (3) begin
      cycle();
      chk("rst_bsy", bsy, 32'h0);
      chk("rst_vld", 32'(clct_vld), 32'h0);
      chk("rst_pat", 32'(clct_pat), 32'h0);
      chk("rst_key", 32'(clct_key), 32'h0);
    end
    reset = 1'b0;
    set_in(1'b1, 7'h62, 5'd20, 1'b0, 3'd3, 4'd4);
    cycle();
    chk("post_rst_vld", 32'(clct_vld), 32'h1);
    chk("post_rst_key", 32'(clct_key), 32'd20);
    clean();

    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].en, vt[i].pat, vt[i].key, vt[i].bb, vt[i].thr, vt[i].dead);
      cycle();
      chk($sformatf("tbl%0d_vld", i), 32'(clct_vld), 32'(vt[i].vld));
      chk($sformatf("tbl%0d_bsy", i), bsy, vt[i].bsy);
      if (vt[i].vld) begin
        chk($sformatf("tbl%0d_pat", i), 32'(clct_pat), 32'(vt[i].pat));
        chk($sformatf("tbl%0d_key", i), 32'(clct_key), 32'(vt[i].key));
      end
      clean();
      chk($sformatf("tbl%0d_clr", i), bsy, 32'h0);
    end

    // busy duration, with dead_bx changed mid-count
    set_in(1'b1, 7'h62, 5'd10, 1'b0, 3'd3, 4'd4);
    cycle();
    idle();
    dead_bx = 4'd9;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bsy[10]) break;
      n++;
      cycle();
    end
    chk("dur_key10", 32'(n), 32'd4);
    clean();

    // same key on consecutive clocks: the sorter pipeline copy must be rejected
    set_in(1'b1, 7'h62, 5'd10, 1'b0, 3'd3, 4'd4);
    cycle();
    n = int'(clct_vld);
    cycle();
    n += int'(clct_vld);
    idle();
    cycle();
    n += int'(clct_vld);
    chk("pipe_vld_count", 32'(n), 32'd1);
    clean();

    // dead_bx=0 allows the same key every clock
    set_in(1'b1, 7'h62, 5'd7, 1'b0, 3'd3, 4'd0);
    n = 0;
    repeat (3) begin
      cycle();
      n += int'(clct_vld);
    end
    chk("b2b_vld_count", 32'(n), 32'd3);
    chk("b2b_bsy", bsy, 32'h0);
    clean();

    // overlapping windows reload, then flush
    set_in(1'b1, 7'h62, 5'd10, 1'b0, 3'd3, 4'd4);
    cycle();
    chk("reload_a", bsy, 32'h0000_1F00);
    idle();
    cycle();
    set_in(1'b1, 7'h62, 5'd13, 1'b0, 3'd3, 4'd4);
    cycle();
    chk("reload_vld", 32'(clct_vld), 32'h1);
    chk("reload_b", bsy, 32'h0000_FF00);
    idle();
    cycle();
    cycle();
    chk("reload_c", bsy, 32'h0000_F800);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_bsy", bsy, 32'h0);

    // flush together with accept: strobe still issued, nothing loaded
    flush = 1'b1;
    set_in(1'b1, 7'h62, 5'd5, 1'b0, 3'd3, 4'd4);
    cycle();
    flush = 1'b0;
    chk("flush_acc_vld", 32'(clct_vld), 32'h1);
    chk("flush_acc_key", 32'(clct_key), 32'd5);
    chk("flush_acc_bsy", bsy, 32'h0);
    idle();
    cycle();
    chk("flush_acc_idle", 32'(clct_vld), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
